// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer definitions: display geometry, framebuffer sizing,
// pixel index type and the frame-clear sequencer states.
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 480;
  localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 4;

  typedef logic [DATA_W-1:0] pix_idx_t;

  localparam pix_idx_t TRANSPARENT_IDX = pix_idx_t'(15);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } fb_clr_state_t;

endpackage

// File: rtl/vga_fb_clear_seq.sv
// Frame-clear sequencer: walks every framebuffer word once with a latched fill
// value, stepping only in cycles where the arbiter grants it the RAM.
module vga_fb_clear_seq #(
  parameter int ADDR_W   = vga_pkg::ADDR_W,
  parameter int DATA_W   = vga_pkg::DATA_W,
  parameter int FB_DEPTH = vga_pkg::FB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] index,
  input  logic              advance,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              idle,
  output logic              busy,
  output logic              done
);
  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  fb_clr_state_t     state;
  fb_clr_state_t     state_next;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    idle       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        req  = 1'b1;
        busy = 1'b1;
        if (advance && count == LAST_ADDR) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fill value is only captured on a start seen in IDLE, so a repeated start
  // mid-clear can neither restart the walk nor change the colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      fill  <= '0;
    end else if (state == IDLE && start) begin
      count <= '0;
      fill  <= index;
    end else if (state == CLEAR && advance && count != LAST_ADDR) begin
      count <= count + 1'b1;
    end
  end

  assign addr = count;
  assign data = fill;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads always win, then the frame
// clear, then renderer writes; display read data returns two cycles later.
module vga_fb_arbiter #(
  parameter int ADDR_W   = vga_pkg::ADDR_W,
  parameter int DATA_W   = vga_pkg::DATA_W,
  parameter int FB_DEPTH = vga_pkg::FB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_index,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);

  logic              clr_req;
  logic              clr_idle;
  logic              clr_advance;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic              wr_fire;
  logic              wr_in_range;
  logic              disp_pend;

  vga_fb_clear_seq #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .FB_DEPTH(FB_DEPTH)
  ) u_clear_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (clear_start),
    .index  (clear_index),
    .advance(clr_advance),
    .req    (clr_req),
    .addr   (clr_addr),
    .data   (clr_data),
    .idle   (clr_idle),
    .busy   (clear_busy),
    .done   (clear_done)
  );

  // Renderer is only served when neither the display nor the clear owns the RAM.
  assign wr_ready    = !disp_req && clr_idle;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = wr_addr < DEPTH_A;
  assign clr_advance = clr_req && !disp_req;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (!rst) begin
      if (disp_req) begin
        ram_addr = disp_addr;
      end else if (clr_req) begin
        ram_addr  = clr_addr;
        ram_we    = 1'b1;
        ram_wdata = clr_data;
      end else if (wr_fire && wr_in_range) begin
        ram_addr  = wr_addr;
        ram_we    = 1'b1;
        ram_wdata = wr_data;
      end
    end
  end

  // Stage 1 tracks the RAM's own read latency, stage 2 registers the data out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_pend  <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      wr_drop    <= 1'b0;
    end else begin
      disp_pend  <= disp_req;
      disp_valid <= disp_pend;
      if (disp_pend) disp_data <= ram_rdata;
      wr_drop    <= wr_fire && !wr_in_range;
    end
  end

endmodule
